// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: control codes, FSM states, default width.
package alu_pkg;

  localparam int ALU_DEFAULT_WIDTH = 32;

  localparam logic [3:0] ALU_CTRL_AND = 4'b0000;
  localparam logic [3:0] ALU_CTRL_OR  = 4'b0001;
  localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
  localparam logic [3:0] ALU_CTRL_XOR = 4'b0011;
  localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;
  localparam logic [3:0] ALU_CTRL_SLT = 4'b0111;
  localparam logic [3:0] ALU_CTRL_MUL = 4'b1000;
  localparam logic [3:0] ALU_CTRL_NOR = 4'b1100;
  localparam logic [3:0] ALU_CTRL_DIV = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } alu_state_e;

  function automatic logic is_multicycle(input logic [3:0] code);
    return (code == ALU_CTRL_MUL) || (code == ALU_CTRL_DIV);
  endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the EX-stage controller (master) and the ALU (slave).
interface alu_multicycle_if #(
  parameter int WIDTH = alu_pkg::ALU_DEFAULT_WIDTH
) ();

  logic             start;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             div_by_zero;
  logic             busy;
  logic             done;

  modport master (
    output start, alu_control, src_a, src_b,
    input  result, result_hi, zero, div_by_zero, busy, done
  );

  modport slave (
    input  start, alu_control, src_a, src_b,
    output result, result_hi, zero, div_by_zero, busy, done
  );

endinterface

// File: rtl/alu_multicycle_mul_div_unit.sv
// Iterative signed MUL/DIV datapath: works on operand magnitudes for WIDTH steps,
// then applies the sign fix-up combinationally from the final registers.
module mul_div_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             last,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             running_q, running_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             neg_b_q, neg_b_d;
  logic             is_div_q, is_div_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0]   mag_a, mag_b, sub_diff;
  logic [WIDTH:0]     add_sum, shifted;
  logic               neg_a;
  logic [2*WIDTH-1:0] prod;

  // MUL: acc:sr is the shifting product, sr starts as the multiplier.
  // DIV: acc is the partial remainder, sr shifts the dividend out and the quotient in.
  always_comb begin
    mag_a    = src_a[WIDTH-1] ? -src_a : src_a;
    mag_b    = src_b[WIDTH-1] ? -src_b : src_b;
    add_sum  = {1'b0, acc_q} + (sr_q[0] ? {1'b0, op_q} : '0);
    shifted  = {acc_q, sr_q[WIDTH-1]};
    sub_diff = shifted[WIDTH-1:0] - op_q;

    running_d = running_q;
    count_d   = count_q;
    acc_d     = acc_q;
    sr_d      = sr_q;
    op_d      = op_q;
    a_d       = a_q;
    neg_b_d   = neg_b_q;
    is_div_d  = is_div_q;
    dbz_d     = dbz_q;

    if (start) begin
      running_d = 1'b1;
      count_d   = '0;
      acc_d     = '0;
      sr_d      = is_div ? mag_a : mag_b;
      op_d      = is_div ? mag_b : mag_a;
      a_d       = src_a;
      neg_b_d   = src_b[WIDTH-1];
      is_div_d  = is_div;
      dbz_d     = is_div && (src_b == '0);
    end else if (running_q) begin
      count_d = count_q + CW'(1);
      if (count_q == CW'(WIDTH - 1)) begin
        running_d = 1'b0;
      end
      if (is_div_q) begin
        if (shifted >= {1'b0, op_q}) begin
          acc_d = sub_diff;
          sr_d  = {sr_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = shifted[WIDTH-1:0];
          sr_d  = {sr_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = add_sum[WIDTH:1];
        sr_d  = {add_sum[0], sr_q[WIDTH-1:1]};
      end
    end
  end

  // Quotient sign is the XOR of operand signs; remainder follows the dividend.
  always_comb begin
    neg_a = a_q[WIDTH-1];
    prod  = {acc_q, sr_q};
    if (neg_a ^ neg_b_q) begin
      prod = -prod;
    end
    if (is_div_q) begin
      if (dbz_q) begin
        res_lo = '1;
        res_hi = a_q;
      end else begin
        res_lo = (neg_a ^ neg_b_q) ? -sr_q : sr_q;
        res_hi = neg_a ? -acc_q : acc_q;
      end
    end else begin
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[2*WIDTH-1:WIDTH];
    end
    div_by_zero = dbz_q;
    last        = running_q && (count_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running_q <= 1'b0;
      count_q   <= '0;
      acc_q     <= '0;
      sr_q      <= '0;
      op_q      <= '0;
      a_q       <= '0;
      neg_b_q   <= 1'b0;
      is_div_q  <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      running_q <= running_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      sr_q      <= sr_d;
      op_q      <= op_d;
      a_q       <= a_d;
      neg_b_q   <= neg_b_d;
      is_div_q  <= is_div_d;
      dbz_q     <= dbz_d;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// EX-stage ALU: single-cycle logic/arith ops plus iterative signed MUL/DIV behind start/busy/done.
// Define ALU_EXT_LOGIC_EN to add XOR (0011) and NOR (1100); otherwise those codes execute ADD.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_DEFAULT_WIDTH
) (
  input logic              clk,
  input logic              rst,
  alu_multicycle_if.slave  bus
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             md_start, md_last, md_dbz;
  logic [WIDTH-1:0] md_lo, md_hi;
  logic [WIDTH-1:0] alu_out;

  mul_div_unit #(.WIDTH(WIDTH)) u_mul_div (
    .clk         (clk),
    .rst         (rst),
    .start       (md_start),
    .is_div      (bus.alu_control == ALU_CTRL_DIV),
    .src_a       (bus.src_a),
    .src_b       (bus.src_b),
    .last        (md_last),
    .res_lo      (md_lo),
    .res_hi      (md_hi),
    .div_by_zero (md_dbz)
  );

  always_comb begin
    case (bus.alu_control)
      ALU_CTRL_AND: alu_out = bus.src_a & bus.src_b;
      ALU_CTRL_OR:  alu_out = bus.src_a | bus.src_b;
      ALU_CTRL_SUB: alu_out = bus.src_a - bus.src_b;
      ALU_CTRL_SLT: alu_out = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
`ifdef ALU_EXT_LOGIC_EN
      ALU_CTRL_XOR: alu_out = bus.src_a ^ bus.src_b;
      ALU_CTRL_NOR: alu_out = ~(bus.src_a | bus.src_b);
`endif
      default:      alu_out = bus.src_a + bus.src_b;
    endcase
  end

  // start is only honoured in IDLE, so a request during RUN/FIX never reaches the datapath.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    dbz_d       = dbz_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    md_start    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (is_multicycle(bus.alu_control)) begin
            md_start = 1'b1;
            busy_d   = 1'b1;
            state_d  = RUN;
          end else begin
            result_d    = alu_out;
            result_hi_d = '0;
            zero_d      = (alu_out == '0);
            dbz_d       = 1'b0;
            done_d      = 1'b1;
          end
        end
      end
      RUN: begin
        if (md_last) begin
          state_d = FIX;
        end
      end
      FIX: begin
        result_d    = md_lo;
        result_hi_d = md_hi;
        zero_d      = (md_lo == '0);
        dbz_d       = md_dbz;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.result      = result_q;
  assign bus.result_hi   = result_hi_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: expected results are queued at issue and popped at done.
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_multicycle_if #(.WIDTH(W)) bus ();

  alu_multicycle #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         zero;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;
  int   lat;
  int   busy_cnt;
  int   done_cnt;

  // Reference model built from plain 64-bit signed arithmetic.
  function automatic exp_t model(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic signed [2*W-1:0] p;
    e = '0;
    case (code)
      ALU_CTRL_AND: e.res = a & b;
      ALU_CTRL_OR:  e.res = a | b;
      ALU_CTRL_SUB: e.res = a - b;
      ALU_CTRL_SLT: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_CTRL_MUL: begin
        p     = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        e.res = p[W-1:0];
        e.hi  = p[2*W-1:W];
      end
      ALU_CTRL_DIV: begin
        if (b == '0) begin
          e.res = '1;
          e.hi  = a;
          e.dbz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.res = 32'h8000_0000;
          e.hi  = '0;
        end else begin
          e.res = $signed(a) / $signed(b);
          e.hi  = $signed(a) % $signed(b);
        end
      end
`ifdef ALU_EXT_LOGIC_EN
      ALU_CTRL_XOR: e.res = a ^ b;
      ALU_CTRL_NOR: e.res = ~(a | b);
`endif
      default:      e.res = a + b;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  task automatic checkValue(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; start is held across exactly one rising edge.
  task automatic applyStimulus(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start       = 1'b1;
    bus.alu_control = code;
    bus.src_a       = a;
    bus.src_b       = b;
    sb.push_back(model(code, a, b));
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // lat = rising edges after the sampling edge until done is seen; busy_cnt = busy cycles before done.
  task automatic waitDone(input int budget);
    bit seen;
    seen     = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (!seen && lat <= budget) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (bus.busy) busy_cnt++;
        @(posedge clk);
        lat++;
      end
    end
    checkValue("done_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    checkValue({tag, ".sb_nonempty"}, {31'd0, (sb.size() != 0)}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkValue({tag, ".result"}, bus.result, e.res);
      checkValue({tag, ".result_hi"}, bus.result_hi, e.hi);
      checkValue({tag, ".zero"}, {31'd0, bus.zero}, {31'd0, e.zero});
      checkValue({tag, ".div_by_zero"}, {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkValue({tag, ".result"}, bus.result, '0);
    checkValue({tag, ".result_hi"}, bus.result_hi, '0);
    checkValue({tag, ".zero"}, {31'd0, bus.zero}, '0);
    checkValue({tag, ".div_by_zero"}, {31'd0, bus.div_by_zero}, '0);
    checkValue({tag, ".busy"}, {31'd0, bus.busy}, '0);
    checkValue({tag, ".done"}, {31'd0, bus.done}, '0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.alu_control = ALU_CTRL_AND;
    bus.src_a       = '0;
    bus.src_b       = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkAllZero("reset");

    // single-cycle ops, each issued in the previous op's done cycle
    applyStimulus(ALU_CTRL_ADD, 32'd5, 32'd7);
    waitDone(50);
    checkValue("add.latency", lat, 32'd0);
    checkValue("add.busy_cycles", busy_cnt, 32'd0);
    checkOutput("add");

    applyStimulus(ALU_CTRL_SLT, 32'hFFFF_FFFB, 32'd3);
    waitDone(50);
    checkOutput("slt_lt");
    applyStimulus(ALU_CTRL_SLT, 32'd3, 32'hFFFF_FFFB);
    waitDone(50);
    checkOutput("slt_ge");
    applyStimulus(ALU_CTRL_SUB, 32'd3, 32'd5);
    waitDone(50);
    checkOutput("sub_neg");
    applyStimulus(ALU_CTRL_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
    waitDone(50);
    checkOutput("and");
    applyStimulus(ALU_CTRL_OR, 32'hF000_0001, 32'h0000_8000);
    waitDone(50);
    checkOutput("or");
    applyStimulus(ALU_CTRL_ADD, 32'hFFFF_FFFF, 32'd1);
    waitDone(50);
    checkOutput("add_wrap");
    applyStimulus(4'b0101, 32'd40, 32'd2);
    waitDone(50);
    checkOutput("unlisted");
    applyStimulus(ALU_CTRL_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F);
    waitDone(50);
    checkOutput("code0011");
    applyStimulus(ALU_CTRL_NOR, 32'hFF00_FF00, 32'h0F0F_0F0F);
    waitDone(50);
    checkOutput("code1100");

    // iterative ops
    applyStimulus(ALU_CTRL_MUL, 32'hFFFF_FFFD, 32'd7);
    waitDone(100);
    checkValue("mul.latency", lat, 32'd33);
    checkValue("mul.busy_cycles", busy_cnt, 32'd33);
    checkValue("mul.busy_in_done", {31'd0, bus.busy}, '0);
    checkOutput("mul_neg");
    applyStimulus(ALU_CTRL_MUL, 32'h8000_0000, 32'h8000_0000);
    waitDone(100);
    checkOutput("mul_minmin");
    applyStimulus(ALU_CTRL_DIV, 32'hFFFF_FFF9, 32'd2);
    waitDone(100);
    checkOutput("div_neg");
    applyStimulus(ALU_CTRL_DIV, 32'd9, 32'd0);
    waitDone(100);
    checkValue("div0.latency", lat, 32'd33);
    checkOutput("div0");
    applyStimulus(ALU_CTRL_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone(100);
    checkOutput("div_ovf");
    applyStimulus(ALU_CTRL_DIV, 32'd7, 32'hFFFF_FFFE);
    waitDone(100);
    checkOutput("div_negdivisor");

    // start while busy is ignored; operands of the running MUL are kept
    applyStimulus(ALU_CTRL_MUL, 32'd100, 32'hFFFF_FFFD);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.alu_control = ALU_CTRL_ADD;
    bus.src_a       = 32'd1;
    bus.src_b       = 32'd2;
    @(posedge clk);
    #1 bus.start = 1'b0;
    waitDone(100);
    checkValue("mul_ignore.latency", lat, 32'd28);
    checkOutput("mul_ignore");

    // back-to-back issue in the done cycle, then done must drop
    applyStimulus(ALU_CTRL_ADD, 32'd1, 32'd2);
    waitDone(50);
    checkValue("b2b.latency", lat, 32'd0);
    checkOutput("b2b_add");
    @(negedge clk);
    checkValue("b2b.done_pulse", {31'd0, bus.done}, '0);

    // reset mid-DIV aborts it without a done
    applyStimulus(ALU_CTRL_DIV, 32'd100, 32'd7);
    void'(sb.pop_back());
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkAllZero("abort");
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    checkValue("abort.no_done", done_cnt, 32'd0);
    applyStimulus(ALU_CTRL_ADD, 32'd20, 32'd22);
    waitDone(50);
    checkOutput("post_abort_add");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
